// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN frame loader.
package cnn_pkg;

  localparam int unsigned NPIX    = 28 * 28;
  localparam int unsigned PIX_W   = 8;
  localparam int unsigned LOGIT_W = 8;

  typedef logic [PIX_W-1:0]   pixel_t;
  typedef logic [LOGIT_W-1:0] logit_t;

  typedef enum logic [1:0] {LOAD, FIRE, WAIT, HOLD} ld_state_e;

  localparam logic CLS_NORMAL    = 1'b0;
  localparam logic CLS_PNEUMONIA = 1'b1;

endpackage

// File: rtl/cnn_argmax2.sv
// Two-way unsigned argmax over CNN logits; a tie resolves to class 1.
module cnn_argmax2 #(
  parameter int unsigned Width = 8
) (
  input  logic [Width-1:0] logit0_i,
  input  logic [Width-1:0] logit1_i,
  output logic             class_o
);
  import cnn_pkg::*;

  always_comb begin
    class_o = (logit0_i > logit1_i) ? CLS_NORMAL : CLS_PNEUMONIA;
  end

endmodule

// File: rtl/cnn_frame_loader.sv
// Streams a frame into a buffer, starts the CNN, and returns its class decision.
// Optional CNN watchdog enabled by defining CNN_TIMEOUT_EN.
module cnn_frame_loader #(
  parameter int unsigned IMG_W          = 28,
  parameter int unsigned IMG_H          = 28,
  parameter int unsigned PIX_W          = 8,
  parameter int unsigned LOGIT_W        = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_pix_valid,
  output logic               s_pix_ready,
  input  logic [PIX_W-1:0]   s_pix_data,
  input  logic               s_pix_last,
  output logic               cnn_valid_in,
  output logic [PIX_W-1:0]   cnn_image [IMG_W*IMG_H],
  input  logic               cnn_valid_out,
  input  logic [LOGIT_W-1:0] cnn_class [2],
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_class,
  output logic [LOGIT_W-1:0] res_logit0,
  output logic [LOGIT_W-1:0] res_logit1,
  output logic               frame_err
);
  import cnn_pkg::*;

  localparam int unsigned NumPix = IMG_W * IMG_H;
  localparam int unsigned CntW   = $clog2(NumPix);
  localparam logic [CntW-1:0] LastIdx = CntW'(NumPix - 1);

  ld_state_e             state_q, state_d;
  logic [CntW-1:0]       pix_cnt_q, pix_cnt_d;
  logic                  res_class_q, res_class_d;
  logic [LOGIT_W-1:0]    logit0_q, logit0_d, logit1_q, logit1_d;
  logic                  frame_err_q, frame_err_d;
  logic [PIX_W-1:0]      buf_q [NumPix];
  logic                  pix_acc;
  logic                  cls_w;

`ifdef CNN_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WdW-1:0] wd_q, wd_d;
`endif

  cnn_argmax2 #(
    .Width(LOGIT_W)
  ) u_argmax (
    .logit0_i(cnn_class[0]),
    .logit1_i(cnn_class[1]),
    .class_o (cls_w)
  );

  always_comb begin
    state_d     = state_q;
    pix_cnt_d   = pix_cnt_q;
    res_class_d = res_class_q;
    logit0_d    = logit0_q;
    logit1_d    = logit1_q;
    frame_err_d = 1'b0;
    pix_acc     = 1'b0;
`ifdef CNN_TIMEOUT_EN
    wd_d        = wd_q;
`endif
    unique case (state_q)
      LOAD: begin
        if (s_pix_valid) begin
          pix_acc = 1'b1;
          if (s_pix_last && (pix_cnt_q == LastIdx)) begin
            state_d   = FIRE;
            pix_cnt_d = '0;
          end else if (s_pix_last || (pix_cnt_q == LastIdx)) begin
            // Early or missing last: drop the frame and resync to index 0.
            frame_err_d = 1'b1;
            pix_cnt_d   = '0;
          end else begin
            pix_cnt_d = pix_cnt_q + 1'b1;
          end
        end
      end
      FIRE: begin
        state_d = WAIT;
`ifdef CNN_TIMEOUT_EN
        wd_d    = '0;
`endif
      end
      WAIT: begin
        if (cnn_valid_out) begin
          logit0_d    = cnn_class[0];
          logit1_d    = cnn_class[1];
          res_class_d = cls_w;
          state_d     = HOLD;
`ifdef CNN_TIMEOUT_EN
        end else if (wd_q == WdW'(TIMEOUT_CYCLES - 1)) begin
          frame_err_d = 1'b1;
          state_d     = LOAD;
        end else begin
          wd_d = wd_q + 1'b1;
`endif
        end
      end
      HOLD: begin
        if (res_ready) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD;
      pix_cnt_q   <= '0;
      res_class_q <= 1'b0;
      logit0_q    <= '0;
      logit1_q    <= '0;
      frame_err_q <= 1'b0;
`ifdef CNN_TIMEOUT_EN
      wd_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      res_class_q <= res_class_d;
      logit0_q    <= logit0_d;
      logit1_q    <= logit1_d;
      frame_err_q <= frame_err_d;
`ifdef CNN_TIMEOUT_EN
      wd_q        <= wd_d;
`endif
    end
  end

  // Frame storage is deliberately unreset; only written while loading.
  always_ff @(posedge clk) begin
    if (pix_acc) buf_q[pix_cnt_q] <= s_pix_data;
  end

  assign s_pix_ready  = (state_q == LOAD);
  assign cnn_valid_in = (state_q == FIRE);
  assign res_valid    = (state_q == HOLD);
  assign res_class    = res_class_q;
  assign res_logit0   = logit0_q;
  assign res_logit1   = logit1_q;
  assign frame_err    = frame_err_q;
  assign cnn_image    = buf_q;

endmodule

// File: doc/cnn_frame_loader.md
Name: cnn_frame_loader

Overview:
- Hardware front/back end for top_cnn. Accepts a streamed 28x28 image over a valid/ready pixel interface and assembles it in a frame buffer.
- Presents the buffer to the CNN, fires a one-cycle start, waits for the CNN result, then reduces the logits to a class decision.
- Returns the decision to the host over a valid/ready result interface.
- Replaces the behavioural image load, start pulse and logit compare with synthesizable logic.

Parameters:
- IMG_W, 28, image width in pixels
- IMG_H, 28, image height in pixels
- PIX_W, 8, pixel width in bits
- LOGIT_W, 8, logit width in bits (unsigned)
- TIMEOUT_CYCLES, 65535, CNN watchdog limit; used only with CNN_TIMEOUT_EN

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- s_pix_valid  in  1  pixel stream valid
- s_pix_ready  out  1  pixel stream ready
- s_pix_data  in  PIX_W  pixel value, raster order
- s_pix_last  in  1  marks final pixel of the frame
- cnn_valid_in  out  1  one-cycle CNN start
- cnn_image  out  PIX_W x (IMG_W*IMG_H) unpacked array, index 0..NPIX-1  frame buffer to the CNN
- cnn_valid_out  in  1  CNN result valid
- cnn_class  in  LOGIT_W x 2 unpacked array  CNN logits [0], [1]
- res_valid  out  1  result valid
- res_ready  in  1  result accepted
- res_class  out  1  0 = Normal, 1 = Pneumonia
- res_logit0, res_logit1  out  LOGIT_W each  captured logits
- frame_err  out  1  one-cycle pulse on a malformed frame or CNN timeout

Behaviour:
- NPIX = IMG_W*IMG_H (784). Pixel counter pix_cnt is $clog2(NPIX) bits wide.
- Reset values: state = LOAD, pix_cnt = 0, and every output is 0 except s_pix_ready = 1 (s_pix_ready is decoded from state). The buffer is not reset.
- FSM states: LOAD, FIRE, WAIT, HOLD.
- LOAD:
  - s_pix_ready = 1. A pixel is accepted on s_pix_valid & s_pix_ready; it is written to buffer[pix_cnt] and pix_cnt increments.
  - Accept with last = 1 and pix_cnt = NPIX-1: go to FIRE, pix_cnt <= 0.
  - Accept with last = 1 and pix_cnt < NPIX-1 (early last), or last = 0 and pix_cnt = NPIX-1 (missing last): frame_err pulses next cycle, pix_cnt <= 0, stay in LOAD, no CNN start.
- FIRE: cnn_valid_in = 1 for exactly one cycle, then go to WAIT. s_pix_ready = 0 from FIRE through HOLD, so the buffer is stable for the whole inference.
- WAIT:
  - On cnn_valid_out, register cnn_class[0] and [1] into res_logit0/1.
  - res_class <= (cnn_class[0] > cnn_class[1]) ? 0 : 1. Comparison is unsigned; a tie selects class 1.
  - Go to HOLD with res_valid = 1 on the next cycle.
  - cnn_valid_out is ignored in every state other than WAIT.
- HOLD:
  - res_valid, res_class and res_logit* hold stable until res_valid & res_ready.
  - On handshake: res_valid <= 0, go to LOAD. s_pix_ready rises the cycle after the handshake; pixels are not accepted in the handshake cycle.
- Latency: last pixel accepted at cycle T gives cnn_valid_in at T+1. cnn_valid_out at cycle U gives res_valid at U+1.
- Reset mid-operation: returns to LOAD immediately. A partial frame is discarded, and a pending result is dropped without a handshake.

Optional Feature:
- Macro: CNN_TIMEOUT_EN.
- Defined: a watchdog counter clears on entry to WAIT and increments each WAIT cycle. If it reaches TIMEOUT_CYCLES without cnn_valid_out, frame_err pulses once, no result is produced, and the FSM returns to LOAD.
- Undefined: no counter exists; WAIT waits indefinitely and frame_err reports frame errors only.

Decomposition:
- Package cnn_pkg: NPIX, PIX_W and LOGIT_W localparams; pixel_t and logit_t typedefs; state enum ld_state_e {LOAD, FIRE, WAIT, HOLD}; class constants CLS_NORMAL = 0, CLS_PNEUMONIA = 1.
- One sub-module, cnn_argmax2: combinational compare of two logits to a class bit, using the tie rule. Instantiated once; the result is registered in the parent.

Test Plan:
- Normal frame: stream 784 pixels (value = index[7:0]), last on pixel 783 -> cnn_valid_in high one cycle at T+1, cnn_image[783] = 0x0F. Model returns logits 0x40/0x10 -> res_valid next cycle, res_class = 0, res_logit0 = 0x40.
- Tie: logits 0x20/0x20 -> res_class = 1. Logits 0x05/0x90 -> res_class = 1.
- Early last on pixel 99 -> frame_err pulses once, cnn_valid_in stays 0. A following correct frame completes normally. Repeat with last missing on pixel 783 -> same response.
- Backpressure: res_ready held 0 for 10 cycles -> res_* stable, s_pix_ready = 0, extra cnn_valid_out pulses ignored. res_ready = 1 -> handshake, s_pix_ready = 1 the next cycle.
- Reset asserted after 300 pixels -> all outputs at reset values immediately. A fresh 784-pixel frame is then accepted from index 0.
- CNN_TIMEOUT_EN with TIMEOUT_CYCLES = 50 and the CNN silent -> frame_err at cycle 50 of WAIT, res_valid stays 0, FSM back in LOAD.
